// File: rtl/shift_add_mac_if.sv
// shift_add_mac_if: handshake/operand bundle for shift_add_mac; master drives start/acc_en/clear_acc/operands, slave returns ready/busy/done/result/overflow
interface shift_add_mac_if #(parameter int WIDTH = 4, parameter int ACC_WIDTH = 2*WIDTH+4);
  logic start, acc_en, clear_acc;
  logic [WIDTH-1:0] multiplicand, multiplier;
  logic ready, busy, done, overflow;
  logic [ACC_WIDTH-1:0] result;
  modport master(output start, acc_en, clear_acc, multiplicand, multiplier, input ready, busy, done, result, overflow);
  modport slave(input start, acc_en, clear_acc, multiplicand, multiplier, output ready, busy, done, result, overflow);
endinterface

// File: rtl/shift_add_mac.sv
// shift_add_mac: sequential shift-add multiply-accumulate; clk/rst plain ports, bus carries start/acc_en/clear_acc/operands in and ready/busy/done/result/overflow out
module shift_add_mac #(
  parameter int WIDTH = 4,
  parameter int ACC_WIDTH = 2*WIDTH+4,
  parameter int SIGNED = 1
) (
  input logic clk,
  input logic rst,
  shift_add_mac_if.slave bus
);
  localparam int CW = $clog2(WIDTH+1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [ACC_WIDTH-1:0] a, part, addend, sum;
  logic [ACC_WIDTH:0] wide;
  logic [WIDTH-1:0] b;
  logic [CW-1:0] cnt;
  logic en, ovf, neg;
  assign bus.ready = state == IDLE;
  assign bus.busy = state != IDLE;
  always_comb begin
    addend = en ? bus.result : '0;
    wide = {1'b0, part} + {1'b0, addend};
    sum = wide[ACC_WIDTH-1:0];
    ovf = (SIGNED != 0) ? (part[ACC_WIDTH-1] == addend[ACC_WIDTH-1]) && (sum[ACC_WIDTH-1] != part[ACC_WIDTH-1]) : wide[ACC_WIDTH];
    neg = (SIGNED != 0) && (cnt == CW'(WIDTH-1));
  end
  // a and b shift each RUN cycle so the current bit is always b[0] and a is already A<<i;
  // the extra RUN cycle at cnt==WIDTH performs the accumulate add
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      part <= '0;
      a <= '0;
      b <= '0;
      en <= 1'b0;
      bus.result <= '0;
      bus.overflow <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.clear_acc) begin
            bus.result <= '0;
            bus.overflow <= 1'b0;
          end
          if (bus.start) begin
            a <= {{(ACC_WIDTH-WIDTH){(SIGNED != 0) && bus.multiplicand[WIDTH-1]}}, bus.multiplicand};
            b <= bus.multiplier;
            en <= bus.acc_en;
            part <= '0;
            cnt <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (cnt == CW'(WIDTH)) begin
            bus.result <= sum;
            bus.overflow <= bus.overflow | (en & ovf);
            bus.done <= 1'b1;
            state <= DONE;
          end else begin
            part <= b[0] ? (neg ? part - a : part + a) : part;
            a <= a << 1;
            b <= b >> 1;
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_add_mac.sv
// tb_shift_add_mac: scoreboard bench running signed and unsigned shift_add_mac instances in lockstep
module tb_shift_add_mac;
  typedef struct {logic [11:0] r; logic o;} exp_t;
  logic clk = 0, rst = 1;
  int total = 0, bad = 0;
  exp_t q_s[$], q_u[$];
  logic [11:0] acc_s = 0, acc_u = 0;
  logic ovf_s = 0, ovf_u = 0;
  always #5 clk = ~clk;
  shift_add_mac_if #(4, 12) ifs();
  shift_add_mac_if #(4, 12) ifu();
  shift_add_mac #(.WIDTH(4), .ACC_WIDTH(12), .SIGNED(1)) dut_s(.clk(clk), .rst(rst), .bus(ifs));
  shift_add_mac #(.WIDTH(4), .ACC_WIDTH(12), .SIGNED(0)) dut_u(.clk(clk), .rst(rst), .bus(ifu));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic drv(input logic st, en, clr, input logic [3:0] a, b);
    ifs.start = st; ifu.start = st;
    ifs.acc_en = en; ifu.acc_en = en;
    ifs.clear_acc = clr; ifu.clear_acc = clr;
    ifs.multiplicand = a; ifu.multiplicand = a;
    ifs.multiplier = b; ifu.multiplier = b;
  endtask
  task automatic model(input logic [3:0] a, b, input logic en, clr);
    int sa, sb, sacc, ss, us;
    exp_t e;
    if (clr) begin acc_s = 0; acc_u = 0; ovf_s = 0; ovf_u = 0; end
    sa = $signed(a); sb = $signed(b); sacc = $signed(acc_s);
    ss = en ? sacc + sa * sb : sa * sb;
    if (ss > 2047 || ss < -2048) ovf_s = 1;
    acc_s = 12'(ss);
    us = en ? int'(acc_u) + int'(a) * int'(b) : int'(a) * int'(b);
    if (us > 4095) ovf_u = 1;
    acc_u = 12'(us);
    e.r = acc_s; e.o = ovf_s; q_s.push_back(e);
    e.r = acc_u; e.o = ovf_u; q_u.push_back(e);
  endtask
  task automatic op(input logic [3:0] a, b, input logic en, clr, noise);
    int lat;
    exp_t e;
    model(a, b, en, clr);
    @(negedge clk);
    drv(1, en, clr, a, b);
    @(negedge clk);
    drv(noise, ~en, 0, ~a, a ^ b ^ 4'h5);
    lat = 1;
    while (!ifs.done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat >= 3) drv(0, 0, 0, 0, 0);
    end
    chk("latency", lat, 6);
    chk("done_u", ifu.done, 1);
    if (q_s.size() == 0 || q_u.size() == 0) chk("queue_empty", 1, 0);
    else begin
      e = q_s.pop_front();
      chk("result_s", ifs.result, e.r);
      chk("ovf_s", ifs.overflow, e.o);
      e = q_u.pop_front();
      chk("result_u", ifu.result, e.r);
      chk("ovf_u", ifu.overflow, e.o);
    end
    @(negedge clk);
    chk("done_pulse", ifs.done, 0);
    chk("ready_after", ifs.ready, 1);
  endtask
  task automatic clear();
    @(negedge clk);
    drv(0, 0, 1, 0, 0);
    @(negedge clk);
    drv(0, 0, 0, 0, 0);
    acc_s = 0; acc_u = 0; ovf_s = 0; ovf_u = 0;
    chk("clr_result_s", ifs.result, 0);
    chk("clr_ovf_s", ifs.overflow, 0);
    chk("clr_result_u", ifu.result, 0);
    chk("clr_ovf_u", ifu.overflow, 0);
  endtask
  initial begin
    drv(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_ready", ifs.ready, 1);
    chk("rst_busy", ifs.busy, 0);
    chk("rst_done", ifs.done, 0);
    chk("rst_result", ifs.result, 0);
    chk("rst_ovf", ifs.overflow, 0);
    rst = 0;
    op(4'd3, 4'd5, 0, 0, 0);
    chk("r_3x5", ifs.result, 12'h00F);
    op(4'h8, 4'h8, 0, 0, 0);
    chk("r_m8xm8", ifs.result, 12'h040);
    op(4'hD, 4'd7, 0, 0, 0);
    chk("r_m3x7", ifs.result, 12'hFEB);
    op(4'hF, 4'hF, 0, 0, 0);
    chk("r_u15x15", ifu.result, 12'h0E1);
    op(4'd3, 4'd5, 0, 0, 0);
    op(4'd2, 4'd2, 1, 0, 0);
    chk("r_acc19", ifs.result, 12'd19);
    clear();
    op(4'd6, 4'd3, 0, 0, 0);
    op(4'd2, 4'd3, 1, 1, 0);
    chk("r_clr_start", ifs.result, 12'd6);
    op(4'd3, 4'd5, 0, 0, 1);
    chk("r_noise", ifs.result, 12'h00F);
    @(negedge clk);
    drv(1, 1, 0, 4'd2, 4'd2);
    @(negedge clk);
    drv(0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    acc_s = 0; acc_u = 0; ovf_s = 0; ovf_u = 0;
    chk("rst_run_done", ifs.done, 0);
    chk("rst_run_ready", ifs.ready, 1);
    chk("rst_run_result", ifs.result, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ifs.done) chk("rst_run_spurious_done", ifs.done, 0);
    end
    op(4'd1, 4'd1, 1, 0, 0);
    chk("r_after_rst", ifs.result, 12'd1);
    clear();
    for (int i = 0; i < 256; i++) op(4'(i >> 4), 4'(i), 0, 0, 0);
    for (int i = 0; i < 45; i++) op(4'd7, 4'd7, 1, 0, 0);
    chk("ovf_set", ifs.overflow, 1);
    op(4'd1, 4'd0, 0, 0, 0);
    chk("ovf_sticky", ifs.overflow, 1);
    clear();
    op(4'd7, 4'd7, 1, 0, 0);
    chk("ovf_cleared", ifs.overflow, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
